// File: rtl/cic_varrate_if.sv
`default_nettype none
// ============================================================================
// Module      : cic_varrate_if
// Description : Sample-stream bundle for the rate-selectable CIC decimator:
//               strobed input samples, rate request, strobed output samples
//               and the rate currently in effect.
// Revision    : 1.0  initial release
// ============================================================================
interface cic_varrate_if #(
  parameter int IN_WIDTH   = 18,
  parameter int OUT_WIDTH  = 20,
  parameter int RATE_WIDTH = 3
);
  logic                         in_strobe;
  logic signed [IN_WIDTH-1:0]   in_data;
  logic [RATE_WIDTH-1:0]        rate_log2;
  logic                         out_strobe;
  logic signed [OUT_WIDTH-1:0]  out_data;
  logic [RATE_WIDTH-1:0]        active_rate_log2;

  // Sample source / sink side
  modport master (
    output in_strobe, in_data, rate_log2,
    input  out_strobe, out_data, active_rate_log2
  );

  // Decimator side
  modport slave (
    input  in_strobe, in_data, rate_log2,
    output out_strobe, out_data, active_rate_log2
  );
endinterface
`default_nettype wire

// File: rtl/cic_varrate.sv
`default_nettype none
// ============================================================================
// Module      : cic_varrate
// Description : Run-time rate-selectable CIC decimator (R = 2^rate_log2).
//               Pipelined integrators, counter-driven decimation strobe,
//               single-cycle comb chain, then gain normalisation with
//               round-half-up and saturation to OUT_WIDTH.
// Revision    : 1.0  initial release
// ============================================================================
module cic_varrate #(
  parameter  int STAGES        = 3,
  parameter  int IN_WIDTH      = 18,
  parameter  int OUT_WIDTH     = 20,
  parameter  int MAX_RATE_LOG2 = 6,
  localparam int ACC_WIDTH     = IN_WIDTH + STAGES * MAX_RATE_LOG2,
  localparam int RATE_WIDTH    = $clog2(MAX_RATE_LOG2 + 1)
) (
  input  logic           clock,
  input  logic           reset,
  cic_varrate_if.slave   bus
);

  localparam int GAIN_BITS = OUT_WIDTH - IN_WIDTH;
  // Headroom for the rounding add and the optional left shift
  localparam int EXT_WIDTH = ACC_WIDTH + 2 + GAIN_BITS;
  localparam int CNT_WIDTH = MAX_RATE_LOG2;
  localparam logic [RATE_WIDTH-1:0]       C_RATE_MAX = RATE_WIDTH'(MAX_RATE_LOG2);
  localparam logic signed [EXT_WIDTH-1:0] C_ONE      = EXT_WIDTH'(1);
  localparam logic signed [EXT_WIDTH-1:0] C_OUT_MAX  =
    EXT_WIDTH'((longint'(1) << (OUT_WIDTH - 1)) - 1);
  localparam logic signed [EXT_WIDTH-1:0] C_OUT_MIN  = ~C_OUT_MAX;

  logic [RATE_WIDTH-1:0]        w_rate_clamped;
  logic                         w_restart;
  logic [RATE_WIDTH-1:0]        r_active;
  logic [CNT_WIDTH-1:0]         r_cnt;
  logic [CNT_WIDTH:0]           w_r_len;
  logic                         w_cnt_last;
  logic                         r_dec;
  logic [ACC_WIDTH-1:0]         w_ext_in;
  logic [ACC_WIDTH-1:0]         r_integ [STAGES];
  logic [ACC_WIDTH-1:0]         r_delay [STAGES];
  logic [ACC_WIDTH-1:0]         w_comb  [STAGES+1];
  logic [ACC_WIDTH-1:0]         r_comb_out;
  logic                         r_comb_vld;
  int                           w_shift;
  logic signed [EXT_WIDTH-1:0]  w_ext;
  logic signed [EXT_WIDTH-1:0]  w_scaled;
  logic [OUT_WIDTH-1:0]         w_sat;
  logic                         r_out_strobe;
  logic [OUT_WIDTH-1:0]         r_out_data;

  // Clamp the requested rate into 1..MAX_RATE_LOG2
  always_comb begin
    w_rate_clamped = bus.rate_log2;
    if (bus.rate_log2 == '0) begin
      w_rate_clamped = RATE_WIDTH'(1);
    end else if (bus.rate_log2 > C_RATE_MAX) begin
      w_rate_clamped = C_RATE_MAX;
    end
  end

  assign w_restart  = (w_rate_clamped != r_active);
  assign w_r_len    = (CNT_WIDTH+1)'(1) << r_active;
  assign w_cnt_last = ({1'b0, r_cnt} == (w_r_len - (CNT_WIDTH+1)'(1)));
  assign w_ext_in   = {{(ACC_WIDTH-IN_WIDTH){bus.in_data[IN_WIDTH-1]}}, bus.in_data};

  // Integrators, frame counter, decimation strobe and rate capture
  always_ff @(posedge clock) begin
    if (reset || w_restart) begin
      for (int k = 0; k < STAGES; k++) r_integ[k] <= '0;
      r_cnt    <= '0;
      r_dec    <= 1'b0;
      r_active <= w_rate_clamped;
    end else begin
      r_dec <= 1'b0;
      if (bus.in_strobe) begin
        r_integ[0] <= r_integ[0] + w_ext_in;
        for (int k = 1; k < STAGES; k++) r_integ[k] <= r_integ[k] + r_integ[k-1];
        if (w_cnt_last) begin
          r_cnt <= '0;
          r_dec <= 1'b1;
        end else begin
          r_cnt <= r_cnt + CNT_WIDTH'(1);
        end
      end
    end
  end

  // Comb differences evaluated as one combinational chain per decimated sample
  assign w_comb[0] = r_integ[STAGES-1];
  for (genvar k = 0; k < STAGES; k++) begin : g_comb
    assign w_comb[k+1] = w_comb[k] - r_delay[k];
  end

  // Comb history and comb result register, updated on the decimation strobe
  always_ff @(posedge clock) begin
    if (reset || w_restart) begin
      for (int k = 0; k < STAGES; k++) r_delay[k] <= '0;
      r_comb_out <= '0;
      r_comb_vld <= 1'b0;
    end else begin
      r_comb_vld <= r_dec;
      if (r_dec) begin
        for (int k = 0; k < STAGES; k++) r_delay[k] <= w_comb[k];
        r_comb_out <= w_comb[STAGES];
      end
    end
  end

  // Gain normalisation: positive shift rounds half up, otherwise zero-fill left shift
  assign w_shift = STAGES * int'(r_active) - GAIN_BITS;

  always_comb begin
    w_ext    = {{(EXT_WIDTH-ACC_WIDTH){r_comb_out[ACC_WIDTH-1]}}, r_comb_out};
    w_scaled = w_ext;
    if (w_shift > 0) begin
      w_scaled = (w_ext + (C_ONE <<< (w_shift - 1))) >>> w_shift;
    end else if (w_shift < 0) begin
      w_scaled = w_ext <<< (-w_shift);
    end
    if (w_scaled > C_OUT_MAX) begin
      w_sat = C_OUT_MAX[OUT_WIDTH-1:0];
    end else if (w_scaled < C_OUT_MIN) begin
      w_sat = C_OUT_MIN[OUT_WIDTH-1:0];
    end else begin
      w_sat = w_scaled[OUT_WIDTH-1:0];
    end
  end

  // Output register: data held between strobes, in-flight result dropped on restart
  always_ff @(posedge clock) begin
    if (reset) begin
      r_out_strobe <= 1'b0;
      r_out_data   <= '0;
    end else if (w_restart) begin
      r_out_strobe <= 1'b0;
    end else begin
      r_out_strobe <= r_comb_vld;
      if (r_comb_vld) r_out_data <= w_sat;
    end
  end

  assign bus.out_strobe       = r_out_strobe;
  assign bus.out_data         = r_out_data;
  assign bus.active_rate_log2 = r_active;

endmodule
`default_nettype wire
